// File: rtl/dtc_ctrl_pkg.sv
// Shared types and widths for the DTC code controller.
package dtc_ctrl_pkg;

  localparam int FRAC_W = 16;
  localparam int DCW_W  = 12;
  localparam int KDTC_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAL   = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

  // One signed LSB step that sticks at 0 and at max instead of wrapping.
  function automatic logic [31:0] sat_step(input logic [31:0] val,
                                           input logic        up,
                                           input logic [31:0] max);
    logic [31:0] res;
    res = val;
    if (up && (val < max))
      res = val + 32'd1;
    else if (!up && (val != 32'd0))
      res = val - 32'd1;
    return res;
  endfunction

endpackage

// File: rtl/dtc_lms_gain.sv
// Sign-sign LMS trainer for the DTC gain code, with the PD-latency matching msb pipe.
module dtc_lms_gain
  import dtc_ctrl_pkg::*;
#(
  parameter int MU_SHIFT = 4,
  parameter int PHE_LAT  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [KDTC_W-1:0] kinit_i,
  input  logic              run_i,
  input  logic              msb_i,
  input  logic              phe_sign_i,
  output logic [KDTC_W-1:0] kdtc_o
);

  localparam int KACC_W = KDTC_W + MU_SHIFT;
  localparam logic [31:0] KACC_MAX = (32'd1 << KACC_W) - 32'd1;

  logic [KACC_W-1:0]  kacc_q, kacc_d;
  logic [PHE_LAT-1:0] pipe_q, pipe_d;
  logic [2:0]         fill_q, fill_d;
  logic               msb_d;

  assign msb_d  = pipe_q[PHE_LAT-1];
  assign kdtc_o = kacc_q[KACC_W-1:MU_SHIFT];

  always_comb begin
    kacc_d = kacc_q;
    pipe_d = pipe_q;
    fill_d = fill_q;
    if (load_i) begin
      kacc_d = {kinit_i, {MU_SHIFT{1'b0}}};
      pipe_d = '0;
      fill_d = '0;
    end else if (run_i) begin
      pipe_d = (pipe_q << 1) | PHE_LAT'(msb_i);
      // Hold the gain until the pipe carries an msb that matches this PHE sample.
      if (fill_q == 3'(PHE_LAT))
        kacc_d = KACC_W'(sat_step(32'(kacc_q), (phe_sign_i == msb_d), KACC_MAX));
      else
        fill_d = fill_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kacc_q <= '0;
      pipe_q <= '0;
      fill_q <= '0;
    end else begin
      kacc_q <= kacc_d;
      pipe_q <= pipe_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/dtc_ctrl.sv
// Reference-rate DTC controller: fractional accumulator, gain-scaled DTC code and timed gain calibration.
module dtc_ctrl
  import dtc_ctrl_pkg::*;
#(
  parameter int MU_SHIFT = 4,
  parameter int PHE_LAT  = 2,
  parameter int CAL_CYC  = 4096
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              EN,
  input  logic              CAL_EN,
  input  logic [FRAC_W-1:0] FCWF,
  input  logic [KDTC_W-1:0] KDTC_INIT,
  input  logic              PHE_SIGN,
  output logic [DCW_W-1:0]  DTCDCW,
  output logic              OVF,
  output logic [KDTC_W-1:0] KDTC,
  output logic              CAL_DONE
);

  localparam int CNT_W = (CAL_CYC > 2) ? $clog2(CAL_CYC) : 1;

  state_e            state_q, state_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [DCW_W-1:0]  dcw_q, dcw_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W:0]   sum;
  logic [FRAC_W-1:0] acc_n;
  logic [DCW_W-1:0]  dcw_n;
  logic              lms_load, lms_run;
  logic [KDTC_W-1:0] kdtc;

  assign sum   = {1'b0, acc_q} + {1'b0, FCWF};
  assign acc_n = sum[FRAC_W-1:0];
  // Full-width product; the top DCW_W bits never exceed 4094 so truncation is safe.
  assign dcw_n = DCW_W'(({{KDTC_W{1'b0}}, acc_n} * {{FRAC_W{1'b0}}, kdtc}) >> FRAC_W);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    dcw_d    = dcw_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    lms_load = 1'b0;
    lms_run  = 1'b0;
    if (!EN) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      dcw_d   = '0;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lms_load = 1'b1;
          acc_d    = '0;
          dcw_d    = '0;
          ovf_d    = 1'b0;
          done_d   = 1'b0;
          cnt_d    = '0;
          state_d  = CAL_EN ? ST_CAL : ST_TRACK;
        end
        ST_CAL: begin
          acc_d   = acc_n;
          ovf_d   = sum[FRAC_W];
          dcw_d   = dcw_n;
          lms_run = 1'b1;
          if (cnt_q == CNT_W'(CAL_CYC - 1)) begin
            state_d = ST_TRACK;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_TRACK: begin
          acc_d = acc_n;
          ovf_d = sum[FRAC_W];
          dcw_d = dcw_n;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      dcw_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dcw_q   <= dcw_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  dtc_lms_gain #(
    .MU_SHIFT(MU_SHIFT),
    .PHE_LAT (PHE_LAT)
  ) u_lms (
    .clk_i     (CLK),
    .rst_ni    (NRST),
    .load_i    (lms_load),
    .kinit_i   (KDTC_INIT),
    .run_i     (lms_run),
    .msb_i     (acc_n[FRAC_W-1]),
    .phe_sign_i(PHE_SIGN),
    .kdtc_o    (kdtc)
  );

  assign DTCDCW   = dcw_q;
  assign OVF      = ovf_q;
  assign KDTC     = kdtc;
  assign CAL_DONE = done_q;

endmodule

// File: tb/tb_dtc_ctrl.sv
// Directed bench for dtc_ctrl with hand-computed expectations (CAL_CYC=64, PHE_LAT=2, MU_SHIFT=4).
module tb_dtc_ctrl;

  logic        CLK = 1'b0;
  logic        NRST;
  logic        EN;
  logic        CAL_EN;
  logic [15:0] FCWF;
  logic [11:0] KDTC_INIT;
  logic        PHE_SIGN;
  logic [11:0] DTCDCW;
  logic        OVF;
  logic [11:0] KDTC;
  logic        CAL_DONE;

  int pass_cnt = 0;
  int total_cnt = 0;

  dtc_ctrl #(.MU_SHIFT(4), .PHE_LAT(2), .CAL_CYC(64)) dut (
    .CLK(CLK), .NRST(NRST), .EN(EN), .CAL_EN(CAL_EN), .FCWF(FCWF),
    .KDTC_INIT(KDTC_INIT), .PHE_SIGN(PHE_SIGN), .DTCDCW(DTCDCW),
    .OVF(OVF), .KDTC(KDTC), .CAL_DONE(CAL_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic go_idle();
    EN = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #3;
    total_cnt++;
    if ({DTCDCW, OVF, KDTC, CAL_DONE} !== 26'd0)
      $display("FAIL reset_state: got dcw=%0d ovf=%0b kdtc=%0d done=%0b, want all 0", DTCDCW, OVF, KDTC, CAL_DONE);
    else pass_cnt++;
    step();
    NRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if ({DTCDCW, OVF, KDTC, CAL_DONE} !== 26'd0)
        $display("FAIL idle_after_reset[%0d]: got dcw=%0d ovf=%0b kdtc=%0d done=%0b, want all 0", i, DTCDCW, OVF, KDTC, CAL_DONE);
      else pass_cnt++;
    end
  endtask

  task automatic test_track();
    logic [11:0] exp_dcw [4];
    exp_dcw[0] = 12'd512; exp_dcw[1] = 12'd1024; exp_dcw[2] = 12'd1536; exp_dcw[3] = 12'd0;
    go_idle();
    CAL_EN = 1'b0; KDTC_INIT = 12'd2048; FCWF = 16'h4000; EN = 1'b1;
    step();
    total_cnt++;
    if (KDTC !== 12'd2048 || DTCDCW !== 12'd0)
      $display("FAIL track_entry: got kdtc=%0d dcw=%0d, want 2048 0", KDTC, DTCDCW);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      if (i >= 2) begin
        CAL_EN = 1'b1;
        PHE_SIGN = 1'($urandom_range(1, 0));
      end
      step();
      total_cnt++;
      if (DTCDCW !== exp_dcw[i % 4] || OVF !== (i % 4 == 3) || KDTC !== 12'd2048 || CAL_DONE !== 1'b0)
        $display("FAIL track_seq[%0d]: got dcw=%0d ovf=%0b kdtc=%0d done=%0b, want dcw=%0d ovf=%0b kdtc=2048 done=0",
                 i, DTCDCW, OVF, KDTC, CAL_DONE, exp_dcw[i % 4], (i % 4 == 3));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midrun();
    NRST = 1'b0;
    #2;
    total_cnt++;
    if ({DTCDCW, OVF, KDTC, CAL_DONE} !== 26'd0)
      $display("FAIL reset_midrun: got dcw=%0d ovf=%0b kdtc=%0d done=%0b, want all 0", DTCDCW, OVF, KDTC, CAL_DONE);
    else pass_cnt++;
    EN = 1'b0;
    step();
    NRST = 1'b1;
    step();
    total_cnt++;
    if ({DTCDCW, OVF, KDTC, CAL_DONE} !== 26'd0)
      $display("FAIL reset_release_idle: got dcw=%0d ovf=%0b kdtc=%0d done=%0b, want all 0", DTCDCW, OVF, KDTC, CAL_DONE);
    else pass_cnt++;
  endtask

  task automatic test_cal_up();
    go_idle();
    CAL_EN = 1'b1; KDTC_INIT = 12'd1000; FCWF = 16'h8000; EN = 1'b1;
    step();
    total_cnt++;
    if (KDTC !== 12'd1000)
      $display("FAIL cal_load: got kdtc=%0d, want 1000", KDTC);
    else pass_cnt++;
    // msb of the accumulator alternates 1,0,... so the 2-cycle delayed msb is 1 on even edges
    for (int k = 0; k < 64; k++) begin
      PHE_SIGN = (k % 2 == 0);
      step();
      if (k == 62) begin
        total_cnt++;
        if (CAL_DONE !== 1'b0)
          $display("FAIL cal_done_early: got done=%0b, want 0", CAL_DONE);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (CAL_DONE !== 1'b1 || KDTC !== 12'd1003)
      $display("FAIL cal_up_end: got done=%0b kdtc=%0d, want 1 1003", CAL_DONE, KDTC);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      PHE_SIGN = 1'($urandom_range(1, 0));
      step();
    end
    total_cnt++;
    if (CAL_DONE !== 1'b1 || KDTC !== 12'd1003)
      $display("FAIL cal_frozen: got done=%0b kdtc=%0d, want 1 1003", CAL_DONE, KDTC);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    go_idle();
    CAL_EN = 1'b1; KDTC_INIT = 12'd4095; FCWF = 16'h0000; PHE_SIGN = 1'b0; EN = 1'b1;
    step();
    for (int k = 0; k < 64; k++) begin
      step();
      if (k == 30) begin
        total_cnt++;
        if (KDTC !== 12'd4095)
          $display("FAIL sat_top_mid: got kdtc=%0d, want 4095", KDTC);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (KDTC !== 12'd4095 || CAL_DONE !== 1'b1)
      $display("FAIL sat_top_end: got kdtc=%0d done=%0b, want 4095 1", KDTC, CAL_DONE);
    else pass_cnt++;
    go_idle();
    KDTC_INIT = 12'd0; PHE_SIGN = 1'b1; EN = 1'b1;
    step();
    for (int k = 0; k < 64; k++) step();
    total_cnt++;
    if (KDTC !== 12'd0 || CAL_DONE !== 1'b1)
      $display("FAIL sat_bottom_end: got kdtc=%0d done=%0b, want 0 1", KDTC, CAL_DONE);
    else pass_cnt++;
  endtask

  task automatic test_en_drop();
    logic m [4];
    m[0] = 1'b0; m[1] = 1'b1; m[2] = 1'b1; m[3] = 1'b0;
    go_idle();
    CAL_EN = 1'b1; KDTC_INIT = 12'd2048; FCWF = 16'h4000; EN = 1'b1;
    step();
    for (int k = 0; k < 34; k++) begin
      PHE_SIGN = m[(k + 2) % 4];
      step();
    end
    total_cnt++;
    if (DTCDCW !== 12'd1024 || KDTC !== 12'd2050)
      $display("FAIL en_drop_pre: got dcw=%0d kdtc=%0d, want 1024 2050", DTCDCW, KDTC);
    else pass_cnt++;
    EN = 1'b0;
    step();
    total_cnt++;
    if (DTCDCW !== 12'd0 || OVF !== 1'b0 || CAL_DONE !== 1'b0 || KDTC !== 12'd2050)
      $display("FAIL en_drop_idle: got dcw=%0d ovf=%0b done=%0b kdtc=%0d, want 0 0 0 2050", DTCDCW, OVF, CAL_DONE, KDTC);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (KDTC !== 12'd2050 || DTCDCW !== 12'd0)
      $display("FAIL en_drop_hold: got kdtc=%0d dcw=%0d, want 2050 0", KDTC, DTCDCW);
    else pass_cnt++;
    EN = 1'b1;
    step();
    total_cnt++;
    if (KDTC !== 12'd2048)
      $display("FAIL reenable_load: got kdtc=%0d, want 2048", KDTC);
    else pass_cnt++;
    for (int k = 0; k < 64; k++) begin
      PHE_SIGN = m[(k + 2) % 4];
      step();
      if (k == 62) begin
        total_cnt++;
        if (CAL_DONE !== 1'b0)
          $display("FAIL reenable_done_early: got done=%0b, want 0", CAL_DONE);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (CAL_DONE !== 1'b1 || KDTC !== 12'd2051)
      $display("FAIL reenable_end: got done=%0b kdtc=%0d, want 1 2051", CAL_DONE, KDTC);
    else pass_cnt++;
  endtask

  task automatic test_en_priority();
    go_idle();
    CAL_EN = 1'b1; KDTC_INIT = 12'd500; FCWF = 16'h0000; PHE_SIGN = 1'b0; EN = 1'b1;
    step();
    for (int k = 0; k < 63; k++) step();
    EN = 1'b0;
    step();
    total_cnt++;
    if (CAL_DONE !== 1'b0 || DTCDCW !== 12'd0)
      $display("FAIL en_priority: got done=%0b dcw=%0d, want 0 0", CAL_DONE, DTCDCW);
    else pass_cnt++;
  endtask

  task automatic test_fcwf_step();
    go_idle();
    CAL_EN = 1'b0; KDTC_INIT = 12'd2048; FCWF = 16'h4000; EN = 1'b1;
    step();
    step();
    total_cnt++;
    if (DTCDCW !== 12'd512 || OVF !== 1'b0)
      $display("FAIL fcwf_pre: got dcw=%0d ovf=%0b, want 512 0", DTCDCW, OVF);
    else pass_cnt++;
    FCWF = 16'h8000;
    step();
    total_cnt++;
    if (DTCDCW !== 12'd1536 || OVF !== 1'b0)
      $display("FAIL fcwf_step1: got dcw=%0d ovf=%0b, want 1536 0", DTCDCW, OVF);
    else pass_cnt++;
    step();
    total_cnt++;
    if (DTCDCW !== 12'd512 || OVF !== 1'b1)
      $display("FAIL fcwf_step2: got dcw=%0d ovf=%0b, want 512 1", DTCDCW, OVF);
    else pass_cnt++;
    step();
    total_cnt++;
    if (DTCDCW !== 12'd1536 || OVF !== 1'b0)
      $display("FAIL fcwf_step3: got dcw=%0d ovf=%0b, want 1536 0", DTCDCW, OVF);
    else pass_cnt++;
  endtask

  initial begin
    NRST = 1'b0; EN = 1'b0; CAL_EN = 1'b0; FCWF = '0; KDTC_INIT = '0; PHE_SIGN = 1'b0;
    test_reset();
    test_track();
    test_reset_midrun();
    test_cal_up();
    test_saturation();
    test_en_drop();
    test_en_priority();
    test_fcwf_step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
